// File: rtl/ttlx8_in_timestamper.sv
// 8-channel TTL input edge timestamper with a registered-output FWFT event FIFO.
// Define TTL_IN_GLITCH_FILTER_EN to add the per-channel FILTER_LEN glitch filter.
module ttlx8_in_timestamper #(
  parameter logic [15:0] DEST_VAL   = 16'h0,
  parameter int          FIFO_DEPTH = 16,
  parameter int          ADDR_LEN   = 4,
  parameter int          FILTER_LEN = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   ttl_in,
  input  logic [63:0]  counter,
  input  logic         enable,
  input  logic [7:0]   rise_mask,
  input  logic [7:0]   fall_mask,
  input  logic         flush,
  input  logic         rti_core_read,
  output logic [127:0] rti_core_dout,
  output logic         rti_core_empty,
  output logic         rti_core_full,
  output logic         overflow_error,
  output logic [31:0]  overflow_count
);

  if (FIFO_DEPTH != (1 << ADDR_LEN) || FILTER_LEN < 1) begin : g_bad_cfg
    $error("ttlx8_in_timestamper: inconsistent parameters");
  end

  logic [7:0]   r_sync1;
  logic [7:0]   r_sync2;
  logic [7:0]   r_prev;
  logic         r_primed;
  logic [7:0]   w_lvl;
  logic [7:0]   w_rise;
  logic [7:0]   w_fall;
  logic         w_event;
  logic [127:0] w_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
      r_primed <= 1'b0;
    end else begin
      r_sync1  <= ttl_in;
      r_sync2  <= r_sync1;
      r_prev   <= w_lvl;
      r_primed <= enable;
    end
  end

`ifdef TTL_IN_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [7:0]     r_filt;
  logic [FCW-1:0] r_fcnt [8];

  // Level only follows sync2 after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt <= '0;
      for (int i = 0; i < 8; i++) begin
        r_fcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_sync2;
`endif

  assign w_rise  = w_lvl & ~r_prev & rise_mask;
  assign w_fall  = ~w_lvl & r_prev & fall_mask;
  assign w_event = r_primed & enable & (|(w_rise | w_fall));
  assign w_word  = {counter, DEST_VAL, 16'h0,
                    w_lvl, 8'h0, w_rise, w_fall};

  logic [127:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_LEN-1:0] r_wr_ptr;
  logic [ADDR_LEN-1:0] r_rd_ptr;
  logic [ADDR_LEN:0]   r_count;
  logic [127:0]        r_dout;
  logic                r_ovf;
  logic [31:0]         r_ovf_cnt;

  logic                w_empty;
  logic                w_full;
  logic                w_rd;
  logic                w_wr;
  logic                w_drop;
  logic [ADDR_LEN-1:0] w_rd_ptr_nxt;
  logic [ADDR_LEN:0]   w_left;
  logic [127:0]        w_dout_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (ADDR_LEN+1)'(FIFO_DEPTH));

  // A flush cycle discards both the read and any new event.
  assign w_rd   = ~flush & rti_core_read & ~w_empty;
  assign w_wr   = ~flush & w_event & (~w_full | w_rd);
  assign w_drop = ~flush & w_event & w_full & ~w_rd;

  assign w_rd_ptr_nxt = r_rd_ptr + ADDR_LEN'(w_rd);
  assign w_left       = r_count - (ADDR_LEN+1)'(w_rd);

  always_comb begin
    w_dout_nxt = r_dout;
    if (w_left != '0) begin
      w_dout_nxt = r_mem[w_rd_ptr_nxt];
    end else if (w_wr) begin
      w_dout_nxt = w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= r_count
                + (ADDR_LEN+1)'(w_wr)
                - (ADDR_LEN+1)'(w_rd);
      r_dout   <= w_dout_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else begin
      r_ovf <= w_drop;
      if (w_drop && r_ovf_cnt != 32'hFFFF_FFFF) begin
        r_ovf_cnt <= r_ovf_cnt + 32'd1;
      end
    end
  end

  assign rti_core_dout  = r_dout;
  assign rti_core_empty = w_empty;
  assign rti_core_full  = w_full;
  assign overflow_error = r_ovf;
  assign overflow_count = r_ovf_cnt;

endmodule
